// File: rtl/adam_pause_gen_pkg.sv
// Purpose: shared types and defaults for the adam_pause_gen pause-request master.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package adam_pause_gen_pkg;

    typedef enum logic [1:0] {
        DELAY = 2'd0,   // counting towards the next request
        REQ   = 2'd1,   // pause_req high, waiting for ack
        HOLD  = 2'd2,   // ack seen, holding the pause
        REL   = 2'd3    // pause_req low, waiting for ack to drop
    } pause_gen_state_t;

    localparam int unsigned DEF_DELAY_CYCLES    = 5000;
    localparam int unsigned DEF_DURATION_CYCLES = 5000;
    localparam int unsigned DEF_CNT_WIDTH       = 32;

    // A cycle parameter of 0 behaves exactly like 1.
    function automatic int unsigned eff_cycles(input int unsigned cycles);
        return (cycles == 0) ? 1 : cycles;
    endfunction

endpackage

// File: rtl/adam_pause_gen.sv
// Purpose: master side of a four-phase pause req/ack handshake; periodically pauses a peer.
// Latency: all outputs registered; pause_req rises DELAY_CYCLES edges after reset/release.
// Backpressure: a request waits indefinitely for ack (no timeout); ack held high in DELAY postpones it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   pause_req  registered pause request to the slave
//   pause_ack  pause acknowledge from the slave
//   busy       registered; high whenever the FSM is outside DELAY
//   inhibit    (only with ADAM_PAUSE_GEN_INHIBIT_EN) blocks new requests while high
module adam_pause_gen
    import adam_pause_gen_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES    = DEF_DELAY_CYCLES,
    parameter int unsigned DURATION_CYCLES = DEF_DURATION_CYCLES,
    parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
`ifdef ADAM_PAUSE_GEN_INHIBIT_EN
    input  logic inhibit,
`endif
    output logic pause_req,
    input  logic pause_ack,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] DLY_LAST = CNT_WIDTH'(eff_cycles(DELAY_CYCLES) - 1);
    localparam logic [CNT_WIDTH-1:0] DUR_LAST = CNT_WIDTH'(eff_cycles(DURATION_CYCLES) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    pause_gen_state_t state_q, state_nxt;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt, cnt_inc;
    logic req_q, req_nxt;
    logic busy_q, busy_nxt;
    logic inh;

`ifdef ADAM_PAUSE_GEN_INHIBIT_EN
    assign inh = inhibit;
`else
    assign inh = 1'b0;
`endif

    // Saturating increment: a long wait in DELAY must never wrap the count
    // back below the threshold.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        req_nxt   = req_q;
        case (state_q)
            DELAY: begin
                req_nxt = 1'b0;
                // Only raise req while ack is low so the handshake stays four-phase.
                if ((cnt_q >= DLY_LAST) && !pause_ack && !inh) begin
                    req_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            REQ: begin
                req_nxt = 1'b1;
                if (pause_ack) begin
                    cnt_nxt   = '0;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                req_nxt = 1'b1;
                if (cnt_q >= DUR_LAST) begin
                    req_nxt   = 1'b0;
                    state_nxt = REL;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            REL: begin
                req_nxt = 1'b0;
                if (!pause_ack) begin
                    cnt_nxt   = '0;
                    state_nxt = DELAY;
                end
            end
            default: begin
                req_nxt   = 1'b0;
                cnt_nxt   = '0;
                state_nxt = DELAY;
            end
        endcase
        // busy is registered from the next state so it lines up with state_q.
        busy_nxt = (state_nxt != DELAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DELAY;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            req_q   <= req_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign pause_req = req_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_adam_pause_gen.sv
// Purpose: self-checking bench for adam_pause_gen (two instances: 4/3 cycles and 0/0 cycles).
// Latency: model advances once per rising edge; outputs compared on every falling edge.
// Backpressure: slave behaviour is directed or randomized by the bench itself.
module tb_adam_pause_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst     = 1'b1;
    logic ack_a   = 1'b0;
    logic ack_b   = 1'b0;
    logic inhibit = 1'b0;
    logic req_a, busy_a, req_b, busy_b;

    adam_pause_gen #(.DELAY_CYCLES(4), .DURATION_CYCLES(3), .CNT_WIDTH(3)) dut_a (
        .clk(clk),
        .rst(rst),
`ifdef ADAM_PAUSE_GEN_INHIBIT_EN
        .inhibit(inhibit),
`endif
        .pause_req(req_a),
        .pause_ack(ack_a),
        .busy(busy_a)
    );

    adam_pause_gen #(.DELAY_CYCLES(0), .DURATION_CYCLES(0), .CNT_WIDTH(4)) dut_b (
        .clk(clk),
        .rst(rst),
`ifdef ADAM_PAUSE_GEN_INHIBIT_EN
        .inhibit(inhibit),
`endif
        .pause_req(req_b),
        .pause_ack(ack_b),
        .busy(busy_b)
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per instance: effective delay/duration, edges elapsed in the delay window,
    // edges left in the hold, and whether ack has been seen for the current request.
    int dly [2] = '{4, 1};
    int dur [2] = '{3, 1};
    bit m_req [2], m_busy [2], m_acked [2];
    int m_el [2], m_hl [2];

    function automatic bit inh_eff();
`ifdef ADAM_PAUSE_GEN_INHIBIT_EN
        return inhibit;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_req[i] = 0; m_busy[i] = 0; m_acked[i] = 0; m_el[i] = 0; m_hl[i] = 0;
        end
    endfunction

    function automatic void model_edge(input int i, input bit a, input bit inh);
        if (!m_busy[i]) begin
            m_el[i]++;
            if (m_el[i] >= dly[i] && !a && !inh) begin
                m_req[i] = 1; m_busy[i] = 1; m_acked[i] = 0;
            end
        end else if (m_req[i] && !m_acked[i]) begin
            if (a) begin m_acked[i] = 1; m_hl[i] = dur[i]; end
        end else if (m_req[i]) begin
            m_hl[i]--;
            if (m_hl[i] == 0) m_req[i] = 0;
        end else if (!a) begin
            m_busy[i] = 0; m_el[i] = 0;
        end
    endfunction

    // One rising edge: advance the model with the inputs the DUT samples, then
    // leave 1 time unit before the caller may change inputs.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_edge(0, ack_a, inh_eff());
            model_edge(1, ack_b, inh_eff());
        end
        edge_n++;
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req_a",  req_a,  m_req[0]);
            chk("busy_a", busy_a, m_busy[0]);
            chk("req_b",  req_b,  m_req[1]);
            chk("busy_b", busy_b, m_busy[1]);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
        ack_a = 1'b0; ack_b = 1'b0;
        edge_n = 0;
    endtask

    // Reset asserted between edges while the peer may still hold ack high.
    task automatic async_reset(input bit lit);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        if (lit) begin
            chk("async_rst_req_a",  req_a,  0);
            chk("async_rst_busy_a", busy_a, 0);
        end
        step();
        rst = 1'b0;
        ack_a = 1'b0; ack_b = 1'b0;
        edge_n = 0;
    endtask

    int  ra1, fa1, ra2, rb1, fb1, rb2, rise_cnt_a, rise_cnt_b;
    bit  pa, pb;

    initial begin
        model_reset();
        rst = 1'b1;
        step();
        chk("reset_req_a",  req_a,  0);
        chk("reset_busy_a", busy_a, 0);
        chk("reset_req_b",  req_b,  0);
        do_reset();
        cmp_en = 1'b1;

        // Slave echoes req with one cycle of lag.
        ra1 = 0; fa1 = 0; ra2 = 0; rb1 = 0; fb1 = 0; rb2 = 0;
        rise_cnt_a = 0; rise_cnt_b = 0;
        for (int k = 0; k < 16; k++) begin
            pa = req_a; pb = req_b;
            step();
            if (!pa && req_a) begin
                rise_cnt_a++;
                if (rise_cnt_a == 1) ra1 = edge_n; else if (rise_cnt_a == 2) ra2 = edge_n;
            end
            if (pa && !req_a && fa1 == 0) fa1 = edge_n;
            if (!pb && req_b) begin
                rise_cnt_b++;
                if (rise_cnt_b == 1) rb1 = edge_n; else if (rise_cnt_b == 2) rb2 = edge_n;
            end
            if (pb && !req_b && fb1 == 0) fb1 = edge_n;
            ack_a = req_a; ack_b = req_b;
        end
        chk("a_first_rise_edge",  ra1, 4);
        chk("a_first_fall_edge",  fa1, 8);
        chk("a_second_rise_edge", ra2, 13);
        chk("b_first_rise_edge",  rb1, 1);
        chk("b_hold_one_cycle_fall_edge", fb1, 3);
        chk("b_second_rise_edge", rb2, 5);

        // Request left unacknowledged for 20 cycles: no timeout.
        do_reset();
        for (int k = 0; k < 4; k++) step();
        chk("req_a_after_delay", req_a, 1);
        for (int k = 0; k < 20; k++) step();
        chk("req_a_no_timeout",  req_a,  1);
        chk("busy_a_no_timeout", busy_a, 1);

        // Reset while in HOLD with ack still high.
        ack_a = 1'b1;
        step();
        step();
        async_reset(1'b1);
        ra1 = 0;
        for (int k = 0; k < 6; k++) begin
            pa = req_a;
            step();
            if (!pa && req_a && ra1 == 0) ra1 = edge_n;
        end
        chk("a_rise_after_reset_edge", ra1, 4);

        // Spurious ack during DELAY (long enough to saturate a 3-bit count).
        do_reset();
        ack_a = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("req_a_held_by_ack", req_a, 0);
        ack_a = 1'b0;
        step();
        chk("req_a_after_ack_drop", req_a, 1);

`ifdef ADAM_PAUSE_GEN_INHIBIT_EN
        // inhibit sampled high on edges 2..10; ack echoes req.
        do_reset();
        ra1 = 0; fa1 = 0;
        for (int k = 0; k < 16; k++) begin
            pa = req_a;
            step();
            if (!pa && req_a && ra1 == 0) ra1 = edge_n;
            if (pa && !req_a && fa1 == 0) fa1 = edge_n;
            ack_a = req_a; ack_b = req_b;
            if (edge_n == 1)  inhibit = 1'b1;
            if (edge_n == 10) inhibit = 1'b0;
            if (edge_n == 12) inhibit = 1'b1;
        end
        inhibit = 1'b0;
        chk("inhibit_rise_edge", ra1, 11);
        chk("inhibit_hold_fall_edge", fa1, 15);
`endif

        // Randomized phase: compliant slave with random latency, or noisy ack.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step();
            if ((k / 200) % 2 == 0) begin
                if ($urandom_range(1, 0) == 1) ack_a = req_a;
                if ($urandom_range(1, 0) == 1) ack_b = req_b;
            end else begin
                ack_a = 1'($urandom_range(1, 0));
                ack_b = 1'($urandom_range(1, 0));
            end
            if ($urandom_range(7, 0) == 0) inhibit = ~inhibit;
            if ($urandom_range(499, 0) == 0) async_reset(1'b0);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adam_pause_gen.md
# adam_pause_gen

Synthesizable pause-request generator acting as the master side of an `ADAM_PAUSE` req/ack handshake. After a programmable delay it requests a pause, holds the pause for a programmable duration once acknowledged, releases it, then repeats. It sits between the `ADAM_SEQ` clock/reset domain and any pausable peripheral (e.g. a timer), exercising its pause/resume path during stress runs.

## Interface
- `DELAY_CYCLES`, default 5000: clock cycles from reset release, or from a completed release, to the next request.
- `DURATION_CYCLES`, default 5000: clock cycles the pause is held after `ack` is seen high.
- `CNT_WIDTH`, default 32: width of the internal cycle counter; must be large enough to hold both cycle parameters.

Ports (clock and reset come from an `ADAM_SEQ` source):
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pause_req` out 1: pause request to the slave (`ADAM_PAUSE.req`); registered.
- `pause_ack` in 1: pause acknowledge from the slave (`ADAM_PAUSE.ack`).
- `busy` out 1: high in any state other than DELAY; registered.
- `inhibit` in 1: present only with `ADAM_PAUSE_GEN_INHIBIT_EN` (see Configuration).

## Operation
- Four-phase handshake:
  - `pause_req` rises only while `pause_ack`=0.
  - `pause_req` stays high until `pause_ack`=1 has been seen and the hold has expired.
  - After `pause_req` falls, the generator waits for `pause_ack`=0 before anything else happens.
- FSM:
  - **DELAY**: counter increments every cycle. When counter ≥ DELAY_CYCLES−1 and `pause_ack`=0, set `pause_req`←1, clear counter, go to REQ. If the count has expired but `pause_ack`=1, wait in DELAY; the counter saturates.
  - **REQ**: `pause_req`=1. When `pause_ack`=1, clear counter and go to HOLD.
  - **HOLD**: counter increments. When counter = DURATION_CYCLES−1, set `pause_req`←0 and go to REL.
  - **REL**: `pause_req`=0. When `pause_ack`=0, clear counter and go to DELAY.
- A parameter value of 0 is treated as 1.
- A spurious `pause_ack` in DELAY is ignored; it only postpones the request.
- The counter never wraps: it saturates at its maximum value.

## Timing
- Reset values: `pause_req`=0, `busy`=0, state DELAY, counter 0. Asynchronous reset mid-operation forces these immediately, even while `ack` is high.
- `pause_req` rises on the DELAY_CYCLES-th rising edge after reset deasserts, provided `ack`=0.
- REQ→HOLD happens on the first edge that samples `ack`=1.
- `pause_req` falls DURATION_CYCLES edges after the REQ→HOLD edge.
- The next DELAY count starts on the edge that samples `ack`=0 in REL.
- No combinational path exists from any input to any output.

## Configuration
- `ADAM_PAUSE_GEN_INHIBIT_EN` defined:
  - Adds input `inhibit`. The DELAY→REQ transition additionally requires `inhibit`=0; the generator waits with a saturated count otherwise.
  - `inhibit` never aborts a request already in REQ, HOLD or REL.
  - This protects critical bus sequences from being paused.
- Undefined: no `inhibit` port; behaviour as if `inhibit`=0.

## Structure
- Package `adam_pause_gen_pkg` holds:
  - the state enum `pause_gen_state_t` {DELAY, REQ, HOLD, REL};
  - the default cycle constants.
- No sub-module; a single FSM plus one shared counter.

## Test plan
- With DELAY_CYCLES=4, DURATION_CYCLES=3 and `ack` following `req` after 1 cycle: `req` rises on the 4th edge after reset, stays high for 1+3 cycles, falls, and rises again 4 edges after `ack` drops.
- With `ack` held 0 for 20 cycles after `req` rises: `req` stays 1 and `busy`=1 for all 20 cycles; no timeout occurs.
- With `ack` forced 1 during DELAY: `req` stays 0 until `ack`=0, then rises on the next edge.
- Assert `rst` while in HOLD: `req`=0 and `busy`=0 immediately; after release the full delay of 4 cycles is counted again.
- With INHIBIT_EN, `inhibit`=1 from cycle 2 to cycle 10: `req` rises on the edge after `inhibit` falls. `inhibit` raised during HOLD does not shorten the 3-cycle hold.
- With DURATION_CYCLES=0: the hold lasts exactly 1 cycle.
